// File: rtl/cnt_en_pkg.sv
// Shared types and helpers for the count-enable generator slice.
package cnt_en_pkg;

    typedef enum logic [0:0] {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } cnt_en_state_t;

    // Counter width helper: never returns 0, so a 1-bit counter is the minimum.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : unsigned'($clog2(n));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability-count debouncer and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce
    import cnt_en_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int unsigned   CW      = clog2_min1(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_dout;
    logic          r_dout_q;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_dout   <= 1'b0;
            r_dout_q <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= din;
            r_sync2  <= r_sync1;
            r_dout_q <= r_dout;
            r_rise   <= r_dout & ~r_dout_q;
            // Any sample that matches the accepted level restarts the stability count.
            if (r_sync2 == r_dout) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_dout <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;

endmodule

// File: rtl/cnt_en_gen.sv
// Count-enable source for the digit counter: single-step pulses per button
// press, or free-running prescaled pulses started/stopped by the button.
module cnt_en_gen
    import cnt_en_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CLK_DIV   = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic mode,
    output logic en,
    output logic btn_db,
    output logic running
);

    localparam int unsigned  PW      = clog2_min1(CLK_DIV);
    localparam logic [PW-1:0] PSC_MAX = PW'(CLK_DIV - 1);

    logic          w_press;
    logic          r_mode_s1;
    logic          r_mode_s2;
    cnt_en_state_t r_state;
    logic [PW-1:0] r_psc;
    logic          r_en;
    logic          r_running;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn_debounce (
        .clk (clk),
        .rst (rst),
        .din (btn_raw),
        .dout(btn_db),
        .rise(w_press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
        end else begin
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_STOP;
            r_psc     <= '0;
            r_en      <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                ST_STOP: begin
                    r_psc <= '0;
                    if (w_press) begin
                        if (r_mode_s2) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end else begin
                            r_en <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Leaving RUN (mode drop or press) suppresses a coincident wrap pulse.
                    if (!r_mode_s2 || w_press) begin
                        r_state   <= ST_STOP;
                        r_running <= 1'b0;
                        r_psc     <= '0;
                    end else if (r_psc == PSC_MAX) begin
                        r_en  <= 1'b1;
                        r_psc <= '0;
                    end else begin
                        r_psc <= r_psc + PW'(1);
                    end
                end
                default: begin
                    r_state   <= ST_STOP;
                    r_running <= 1'b0;
                    r_psc     <= '0;
                end
            endcase
        end
    end

    assign en      = r_en;
    assign running = r_running;

endmodule

// File: tb/tb_cnt_en_gen.sv
// Directed bench for cnt_en_gen with DB_CYCLES=4, CLK_DIV=5.
module tb_cnt_en_gen;

    localparam int unsigned DB  = 4;
    localparam int unsigned DIV = 5;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic btn_raw = 1'b0;
    logic mode    = 1'b0;
    logic en;
    logic btn_db;
    logic running;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    cnt_en_gen #(
        .DB_CYCLES(DB),
        .CLK_DIV  (DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .mode   (mode),
        .en     (en),
        .btn_db (btn_db),
        .running(running)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_raw = 1'($urandom_range(0, 1));
            mode    = 1'($urandom_range(0, 1));
            tick();
            total++; if (en !== 1'b0)      begin bad++; $display("FAIL rst_en i=%0d got=%b want=0", i, en); end
            total++; if (btn_db !== 1'b0)  begin bad++; $display("FAIL rst_db i=%0d got=%b want=0", i, btn_db); end
            total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_run i=%0d got=%b want=0", i, running); end
        end
        btn_raw = 1'b0;
        mode    = 1'b0;
        rst     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (en !== 1'b0)      begin bad++; $display("FAIL rel_en i=%0d got=%b want=0", i, en); end
            total++; if (btn_db !== 1'b0)  begin bad++; $display("FAIL rel_db i=%0d got=%b want=0", i, btn_db); end
            total++; if (running !== 1'b0) begin bad++; $display("FAIL rel_run i=%0d got=%b want=0", i, running); end
        end
    endtask

    // Press held 20 cycles: btn_db up at +6, en at +8, btn_db down at +26.
    task automatic test_step;
        logic x_db, x_en;
        int   n_en;
        n_en    = 0;
        btn_raw = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            x_db = (k >= 6 && k < 26);
            x_en = (k == 8);
            n_en += int'(en);
            total++; if (btn_db !== x_db)  begin bad++; $display("FAIL step_db k=%0d got=%b want=%b", k, btn_db, x_db); end
            total++; if (en !== x_en)      begin bad++; $display("FAIL step_en k=%0d got=%b want=%b", k, en, x_en); end
            total++; if (running !== 1'b0) begin bad++; $display("FAIL step_run k=%0d got=%b want=0", k, running); end
            btn_raw = (k < 20);
        end
        total++; if (n_en != 1) begin bad++; $display("FAIL step_count got=%0d want=1", n_en); end
    endtask

    // Raw 1,0,1,0,1 then steady 1: only the final stable run is accepted (+10), en at +12.
    task automatic test_bounce;
        logic [4:0] pat;
        logic       x_db, x_en;
        int         n_en;
        pat     = 5'b10101;
        n_en    = 0;
        btn_raw = pat[0];
        for (int k = 1; k <= 26; k++) begin
            tick();
            x_db = (k >= 10 && k < 22);
            x_en = (k == 12);
            n_en += int'(en);
            total++; if (btn_db !== x_db) begin bad++; $display("FAIL bnc_db k=%0d got=%b want=%b", k, btn_db, x_db); end
            total++; if (en !== x_en)     begin bad++; $display("FAIL bnc_en k=%0d got=%b want=%b", k, en, x_en); end
            btn_raw = (k <= 4) ? pat[k] : (k < 16);
        end
        total++; if (n_en != 1) begin bad++; $display("FAIL bnc_count got=%0d want=1", n_en); end
    endtask

    // Run entered at +8, pulses at +13,18,...; second press stops at +38, which
    // coincides with a wrap that must be suppressed.
    task automatic test_free_run;
        logic x_db, x_en, x_run;
        int   n_win;
        n_win = 0;
        mode  = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        btn_raw = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            x_run = (k >= 8 && k < 38);
            x_en  = (k >= 13 && k < 38 && ((k - 13) % 5) == 0);
            x_db  = (k >= 6 && k < 26) || (k >= 36 && k < 56);
            if (k >= 9 && k <= 28) n_win += int'(en);
            total++; if (running !== x_run) begin bad++; $display("FAIL run_run k=%0d got=%b want=%b", k, running, x_run); end
            total++; if (en !== x_en)       begin bad++; $display("FAIL run_en k=%0d got=%b want=%b", k, en, x_en); end
            total++; if (btn_db !== x_db)   begin bad++; $display("FAIL run_db k=%0d got=%b want=%b", k, btn_db, x_db); end
            btn_raw = (k < 20) || (k >= 30 && k < 50);
        end
        total++; if (n_win != 4) begin bad++; $display("FAIL run_window got=%0d want=4", n_win); end
    endtask

    // Mode drop timed so the synchronised mode reaches the FSM on the wrap edge
    // (+18): stop wins, so only the +13 pulse appears.
    task automatic test_mode_drop;
        logic x_en, x_run;
        btn_raw = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            x_run = (k >= 8 && k < 18);
            x_en  = (k == 13);
            total++; if (running !== x_run) begin bad++; $display("FAIL mdrop_run k=%0d got=%b want=%b", k, running, x_run); end
            total++; if (en !== x_en)       begin bad++; $display("FAIL mdrop_en k=%0d got=%b want=%b", k, en, x_en); end
            btn_raw = (k < 20);
            if (k == 15) mode = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run;
        logic x_db, x_en, x_run;
        mode = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        btn_raw = 1'b1;
        for (int k = 1; k <= 20; k++) tick();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL mid_pre_run got=%b want=1", running); end
        rst = 1'b0;
        #1;
        total++; if (en !== 1'b0)      begin bad++; $display("FAIL mid_rst_en got=%b want=0", en); end
        total++; if (btn_db !== 1'b0)  begin bad++; $display("FAIL mid_rst_db got=%b want=0", btn_db); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL mid_rst_run got=%b want=0", running); end
        tick();
        rst = 1'b1;
        for (int r = 1; r <= 15; r++) begin
            tick();
            x_db  = (r >= 6);
            x_run = (r >= 8);
            x_en  = (r == 13);
            total++; if (btn_db !== x_db)   begin bad++; $display("FAIL mid1_db r=%0d got=%b want=%b", r, btn_db, x_db); end
            total++; if (running !== x_run) begin bad++; $display("FAIL mid1_run r=%0d got=%b want=%b", r, running, x_run); end
            total++; if (en !== x_en)       begin bad++; $display("FAIL mid1_en r=%0d got=%b want=%b", r, en, x_en); end
        end
        rst  = 1'b0;
        mode = 1'b0;
        #1;
        total++; if (running !== 1'b0) begin bad++; $display("FAIL mid2_rst_run got=%b want=0", running); end
        tick();
        rst = 1'b1;
        for (int r = 1; r <= 12; r++) begin
            tick();
            x_db = (r >= 6);
            x_en = (r == 8);
            total++; if (btn_db !== x_db)   begin bad++; $display("FAIL mid2_db r=%0d got=%b want=%b", r, btn_db, x_db); end
            total++; if (running !== 1'b0)  begin bad++; $display("FAIL mid2_run r=%0d got=%b want=0", r, running); end
            total++; if (en !== x_en)       begin bad++; $display("FAIL mid2_en r=%0d got=%b want=%b", r, en, x_en); end
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    initial begin
        test_reset();
        test_step();
        test_bounce();
        test_free_run();
        test_mode_drop();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

endmodule
